// File: rtl/psum_acc_bank_pkg.sv
// Shared FSM encoding and mode constants for the partial-sum accumulator bank.
package psum_acc_bank_pkg;

  // state    | meaning
  // ST_IDLE  | waiting; mode_sel decides where the first beat goes
  // ST_ACC   | weight-stationary accumulation into the entry bank
  // ST_OS    | output-stationary pass-through, one-beat register
  // ST_DRAIN | streaming entries 0..depth-1 out, clearing each one
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_OS    = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

endpackage

// File: rtl/psum_lane_sat.sv
// Signed saturating adder for one lane; ovf flags a clamped result.
module psum_lane_sat #(
  parameter int psum_bw = 16
) (
  input  logic signed [psum_bw-1:0] a,
  input  logic signed [psum_bw-1:0] b,
  output logic signed [psum_bw-1:0] sum,
  output logic                      ovf
);

  logic signed [psum_bw:0] full;

  // One guard bit exposes overflow as a mismatch of the top two bits.
  always_comb begin
    full = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    ovf  = full[psum_bw] ^ full[psum_bw-1];
    sum  = full[psum_bw-1:0];
    if (ovf) begin
      sum = full[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
    end
  end

endmodule

// File: rtl/psum_acc_bank.sv
// Partial-sum accumulator bank: WS accumulation into depth entries with an
// ordered drain, or OS single-beat pass-through. ReLU only on the output path.
module psum_acc_bank
  import psum_acc_bank_pkg::*;
#(
  parameter  int col     = 8,
  parameter  int psum_bw = 16,
  parameter  int depth   = 16,
  localparam int addr_bw = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode_sel,
  input  logic                     relu_en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [psum_bw*col-1:0]   in_data,
  input  logic [addr_bw-1:0]       in_addr,
  input  logic                     in_first,
  input  logic                     drain_start,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [psum_bw*col-1:0]   out_data,
  output logic [addr_bw-1:0]       out_addr,
  output logic                     busy,
  output logic                     ovf
);

  localparam int data_bw = psum_bw * col;
  localparam logic [addr_bw-1:0] last_addr = addr_bw'(depth - 1);

  state_t               state, state_nxt;
  logic [data_bw-1:0]   mem [depth];
  logic [data_bw-1:0]   os_data;
  logic                 os_valid;
  logic [addr_bw-1:0]   drain_ptr;
  logic                 ovf_q;

  logic [data_bw-1:0]   rd_entry, sum_data, raw_out;
  logic [col-1:0]       lane_ovf;
  logic                 rdy_c, acc_we, os_load, drain_hs, go_drain;

  assign rd_entry = mem[in_addr];

  for (genvar g = 0; g < col; g++) begin : g_lane
    psum_lane_sat #(.psum_bw(psum_bw)) u_sat (
      .a   (rd_entry[g*psum_bw +: psum_bw]),
      .b   (in_data[g*psum_bw +: psum_bw]),
      .sum (sum_data[g*psum_bw +: psum_bw]),
      .ovf (lane_ovf[g])
    );
  end

  // Next-state and handshake decode. An OS beat in IDLE takes priority over a
  // coincident drain_start, since the bank then belongs to pass-through mode.
  always_comb begin
    state_nxt = state;
    rdy_c     = 1'b0;
    acc_we    = 1'b0;
    os_load   = 1'b0;
    drain_hs  = 1'b0;
    case (state)
      ST_IDLE: begin
        rdy_c = 1'b1;
        if (in_valid && mode_sel == MODE_OS) begin
          os_load   = 1'b1;
          state_nxt = ST_OS;
        end else begin
          acc_we = in_valid;
          if (drain_start)   state_nxt = ST_DRAIN;
          else if (in_valid) state_nxt = ST_ACC;
        end
      end
      ST_ACC: begin
        rdy_c  = 1'b1;
        acc_we = in_valid;
        if (drain_start) state_nxt = ST_DRAIN;
      end
      ST_OS: begin
        rdy_c   = !os_valid || out_ready;
        os_load = in_valid && rdy_c;
        if (!os_valid && !in_valid) state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        drain_hs = out_ready;
        if (out_ready && drain_ptr == last_addr) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    go_drain = (state_nxt == ST_DRAIN) && (state != ST_DRAIN);
  end

  // Output mux with per-lane rectification; entries themselves stay signed.
  always_comb begin
    raw_out   = (state == ST_DRAIN) ? mem[drain_ptr] : os_data;
    out_data  = raw_out;
    if (relu_en) begin
      for (int i = 0; i < col; i++) begin
        if (raw_out[i*psum_bw + psum_bw - 1]) out_data[i*psum_bw +: psum_bw] = '0;
      end
    end
    out_valid = (state == ST_DRAIN) ? 1'b1 : os_valid;
    out_addr  = (state == ST_DRAIN) ? drain_ptr : '0;
    in_ready  = reset && rdy_c;
    busy      = (state != ST_IDLE);
    ovf       = ovf_q;
  end

  // State, entry bank, OS holding register, drain pointer and sticky ovf.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      for (int i = 0; i < depth; i++) mem[i] <= '0;
      os_data   <= '0;
      os_valid  <= 1'b0;
      drain_ptr <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (acc_we) mem[in_addr] <= in_first ? in_data : sum_data;
      if (drain_hs) begin
        mem[drain_ptr] <= '0;
        drain_ptr      <= (drain_ptr == last_addr) ? '0 : drain_ptr + addr_bw'(1);
      end
      if (os_load) begin
        os_data  <= in_data;
        os_valid <= 1'b1;
      end else if (out_ready) begin
        os_valid <= 1'b0;
      end
      if (go_drain) ovf_q <= 1'b0;
      else if (acc_we && !in_first && |lane_ovf) ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psum_acc_bank.sv
// Directed bench for psum_acc_bank with col=8, psum_bw=16, depth=16.
module tb_psum_acc_bank;
  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int DEP = 16;
  localparam int AW  = 4;
  localparam int DW  = COL * BW;

  logic          clk = 1'b0;
  logic          reset, mode_sel, relu_en, in_valid, in_first, drain_start, out_ready;
  logic          in_ready, out_valid, busy, ovf;
  logic [DW-1:0] in_data, out_data;
  logic [AW-1:0] in_addr, out_addr;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] drained [DEP];
  int beats;
  bit order_ok;

  psum_acc_bank #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
    .clk(clk), .reset(reset), .mode_sel(mode_sel), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_addr(in_addr),
    .in_first(in_first), .drain_start(drain_start), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pack_all(input logic [BW-1:0] x);
    logic [DW-1:0] v;
    for (int i = 0; i < COL; i++) v[i*BW +: BW] = x;
    return v;
  endfunction

  function automatic logic [DW-1:0] pack2(input logic [BW-1:0] l0, input logic [BW-1:0] l1,
                                          input logic [BW-1:0] l2);
    logic [DW-1:0] v = '0;
    v[0 +: BW]    = l0;
    v[BW +: BW]   = l1;
    v[2*BW +: BW] = l2;
    return v;
  endfunction

  task automatic write_beat(input int addr, input bit first, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_addr  = AW'(addr);
    in_first = first;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic drain_collect(input bit pulse);
    int n = 0;
    if (pulse) begin
      drain_start = 1'b1;
      step();
      drain_start = 1'b0;
    end
    out_ready = 1'b1;
    beats = 0;
    order_ok = 1'b1;
    for (int i = 0; i < DEP; i++) drained[i] = 'x;
    while (busy && n < 200) begin
      if (out_valid) begin
        if (out_addr != AW'(beats)) order_ok = 1'b0;
        drained[out_addr] = out_data;
        beats++;
      end
      step();
      n++;
    end
    out_ready = 1'b0;
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL drain_timeout busy=%0b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks += 6;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b exp 0", busy); end
    if (ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf got %b exp 0", ovf); end
    if (out_data !== '0) begin failures++; $display("FAIL rst_out_data got %h exp 0", out_data); end
    if (out_addr !== '0) begin failures++; $display("FAIL rst_out_addr got %h exp 0", out_addr); end
    reset = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_accumulate();
    write_beat(3, 1'b1, pack_all(16'd5));
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL acc_busy got %b exp 1", busy); end
    write_beat(3, 1'b0, pack_all(16'd7));
    write_beat(3, 1'b0, pack_all(16'd2));
    drain_collect(1'b1);
    checks += 3;
    if (beats != DEP) begin failures++; $display("FAIL acc_beats got %0d exp %0d", beats, DEP); end
    if (!order_ok) begin failures++; $display("FAIL acc_order got out-of-order exp ascending"); end
    if (ovf !== 1'b0) begin failures++; $display("FAIL acc_ovf got %b exp 0", ovf); end
    for (int i = 0; i < DEP; i++) begin
      checks++;
      if (drained[i] !== ((i == 3) ? pack_all(16'd14) : '0)) begin
        failures++;
        $display("FAIL acc_entry%0d got %h exp %h", i, drained[i], (i == 3) ? pack_all(16'd14) : '0);
      end
    end
  endtask

  task automatic test_saturation();
    write_beat(1, 1'b1, pack2(16'd32760, -16'sd32760, 16'd0));
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("FAIL sat_ovf_first got %b exp 0", ovf); end
    write_beat(1, 1'b0, pack2(16'd100, -16'sd100, 16'd3));
    checks++;
    if (ovf !== 1'b1) begin failures++; $display("FAIL sat_ovf got %b exp 1", ovf); end
    drain_collect(1'b1);
    checks += 2;
    if (drained[1] !== pack2(16'h7FFF, 16'h8000, 16'd3)) begin
      failures++;
      $display("FAIL sat_entry1 got %h exp %h", drained[1], pack2(16'h7FFF, 16'h8000, 16'd3));
    end
    if (ovf !== 1'b0) begin failures++; $display("FAIL sat_ovf_clear got %b exp 0", ovf); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] e5;
    int n = 0;
    for (int i = 0; i < COL; i++) e5[i*BW +: BW] = BW'(i * 1000 - 3000);
    write_beat(4, 1'b1, pack_all(16'd44));
    write_beat(5, 1'b1, e5);
    drain_start = 1'b1;
    out_ready = 1'b0;
    step();
    drain_start = 1'b0;
    while (out_addr != AW'(5) && n < 40) begin
      out_ready = 1'b1;
      step();
      n++;
    end
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid c%0d got %b exp 1", c, out_valid); end
      if (out_addr !== AW'(5)) begin failures++; $display("FAIL stall_addr c%0d got %0d exp 5", c, out_addr); end
      if (out_data !== e5) begin failures++; $display("FAIL stall_data c%0d got %h exp %h", c, out_data, e5); end
    end
    out_ready = 1'b1;
    step();
    checks += 2;
    if (out_addr !== AW'(6)) begin failures++; $display("FAIL stall_next_addr got %0d exp 6", out_addr); end
    if (out_data !== '0) begin failures++; $display("FAIL stall_next_data got %h exp 0", out_data); end
    drain_collect(1'b0);
    drain_collect(1'b1);
    checks += 2;
    if (drained[5] !== '0) begin failures++; $display("FAIL stall_entry5_zero got %h exp 0", drained[5]); end
    if (drained[4] !== '0) begin failures++; $display("FAIL stall_entry4_zero got %h exp 0", drained[4]); end
  endtask

  task automatic test_os();
    mode_sel  = 1'b1;
    relu_en   = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_addr   = '0;
    in_data   = pack2(-16'sd4, 16'd9, 16'd0);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL os_ready_idle got %b exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks += 4;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL os_valid got %b exp 1", out_valid); end
    if (out_data !== pack2(16'd0, 16'd9, 16'd0)) begin
      failures++; $display("FAIL os_relu_data got %h exp %h", out_data, pack2(16'd0, 16'd9, 16'd0));
    end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL os_ready_stall got %b exp 0", in_ready); end
    if (out_addr !== '0) begin failures++; $display("FAIL os_addr got %0d exp 0", out_addr); end
    relu_en = 1'b0;
    #1;
    checks++;
    if (out_data !== pack2(16'hFFFC, 16'd9, 16'd0)) begin
      failures++; $display("FAIL os_raw_data got %h exp %h", out_data, pack2(16'hFFFC, 16'd9, 16'd0));
    end
    drain_start = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL os_ready_free got %b exp 1", in_ready); end
    step();
    drain_start = 1'b0;
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL os_valid_drop got %b exp 0", out_valid); end
    if (busy !== 1'b1) begin failures++; $display("FAIL os_busy got %b exp 1", busy); end
    step();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL os_idle got busy=%b exp 0", busy); end
    mode_sel  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    int n = 0;
    write_beat(6, 1'b1, pack_all(16'd66));
    write_beat(9, 1'b1, pack_all(16'd99));
    drain_start = 1'b1;
    step();
    drain_start = 1'b0;
    out_ready = 1'b1;
    while (out_addr != AW'(6) && n < 40) begin
      step();
      n++;
    end
    reset = 1'b0;
    step();
    checks += 4;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got %b exp 0", in_ready); end
    if (out_addr !== '0) begin failures++; $display("FAIL mid_rst_addr got %0d exp 0", out_addr); end
    reset = 1'b1;
    out_ready = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_idle got busy=%b exp 0", busy); end
    drain_collect(1'b1);
    for (int i = 0; i < DEP; i++) begin
      checks++;
      if (drained[i] !== '0) begin failures++; $display("FAIL mid_rst_entry%0d got %h exp 0", i, drained[i]); end
    end
  endtask

  task automatic test_drain_with_beat();
    write_beat(0, 1'b1, pack_all(16'd10));
    in_valid    = 1'b1;
    in_addr     = '0;
    in_first    = 1'b0;
    in_data     = pack_all(16'd4);
    drain_start = 1'b1;
    step();
    in_valid    = 1'b0;
    drain_start = 1'b0;
    checks += 4;
    if (busy !== 1'b1) begin failures++; $display("FAIL dwb_busy got %b exp 1", busy); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL dwb_ready got %b exp 0", in_ready); end
    if (out_addr !== '0) begin failures++; $display("FAIL dwb_addr got %0d exp 0", out_addr); end
    if (out_data !== pack_all(16'd14)) begin
      failures++; $display("FAIL dwb_data got %h exp %h", out_data, pack_all(16'd14));
    end
    drain_collect(1'b0);
    checks += 2;
    if (drained[0] !== pack_all(16'd14)) begin
      failures++; $display("FAIL dwb_entry0 got %h exp %h", drained[0], pack_all(16'd14));
    end
    if (beats != DEP) begin failures++; $display("FAIL dwb_beats got %0d exp %0d", beats, DEP); end
  endtask

  initial begin
    reset = 1'b0; mode_sel = 1'b0; relu_en = 1'b0; in_valid = 1'b0; in_first = 1'b0;
    drain_start = 1'b0; out_ready = 1'b0; in_data = '0; in_addr = '0;
    test_reset();
    test_accumulate();
    test_saturation();
    test_stall();
    test_os();
    test_reset_mid_drain();
    test_drain_with_beat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
